// File: rtl/serial_encoder_8to3_if.sv
// Handshake bundle for the 8-to-3 serial encoder: vector input stream and code output stream.
interface serial_encoder_8to3_if;
  logic       in_valid;
  logic [7:0] in_vec;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] out_code;
  logic       out_last;
  logic       out_ready;

  // master is the environment around the encoder; slave is the encoder itself
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_code, out_last
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_code, out_last
  );
endinterface

// File: rtl/serial_encoder_8to3.sv
// Sequential 8-to-3 encoder: captures a multi-hot line vector and emits the index of each
// set line, one code per accepted beat, in fixed priority order.
module serial_encoder_8to3 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  serial_encoder_8to3_if.slave        bus,
  output logic                        busy
);

  localparam logic StIdle = 1'b0;
  localparam logic StEmit = 1'b1;

  logic       state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] sel;
  logic       single;
  logic       emit;

  // Last match in the scan wins, so scan direction sets the priority.
  always_comb begin
    sel = 3'd0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (pend_q[i]) sel = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pend_q[i]) sel = 3'(i);
      end
    end
  end

  assign single = (pend_q != 8'd0) && ((pend_q & (pend_q - 8'd1)) == 8'd0);
  assign emit   = (state_q == StEmit);

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = emit;
  assign bus.out_code  = emit ? sel : 3'd0;
  assign bus.out_last  = emit & single;
  assign busy          = emit;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      StIdle: begin
        // An all-zero vector is accepted and dropped without producing a beat.
        if (bus.in_valid && (bus.in_vec != 8'd0)) begin
          pend_d  = bus.in_vec;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          pend_d = pend_q & ~(8'd1 << sel);
          if (single) state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_serial_encoder_8to3.sv
// Directed bench for serial_encoder_8to3: one LSB-first and one MSB-first instance.
module tb_serial_encoder_8to3;

  logic clk;
  logic rst;
  logic busy_lo;
  logic busy_hi;

  int n_checks = 0;
  int n_fail   = 0;

  serial_encoder_8to3_if if_lo ();
  serial_encoder_8to3_if if_hi ();

  serial_encoder_8to3 #(.MSB_FIRST(1'b0)) u_dut_lo (
    .clk  (clk),
    .rst  (rst),
    .bus  (if_lo.slave),
    .busy (busy_lo)
  );

  serial_encoder_8to3 #(.MSB_FIRST(1'b1)) u_dut_hi (
    .clk  (clk),
    .rst  (rst),
    .bus  (if_hi.slave),
    .busy (busy_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int codes_lo [4] = '{1, 2, 5, 7};
  int codes_hi [4] = '{7, 5, 2, 1};

  initial begin
    rst             = 1'b1;
    if_lo.in_valid  = 1'b0;
    if_lo.in_vec    = 8'd0;
    if_lo.out_ready = 1'b0;
    if_hi.in_valid  = 1'b0;
    if_hi.in_vec    = 8'd0;
    if_hi.out_ready = 1'b0;

    // Reset, then idle with no input traffic
    step();
    step();
    check_eq("rst_in_ready", 32'(if_lo.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(if_lo.out_valid), 32'd0);
    check_eq("rst_out_code", 32'(if_lo.out_code), 32'd0);
    check_eq("rst_out_last", 32'(if_lo.out_last), 32'd0);
    check_eq("rst_busy", 32'(busy_lo), 32'd0);
    check_eq("rst_busy_hi", 32'(busy_hi), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("idle_out_valid", 32'(if_lo.out_valid), 32'd0);
      check_eq("idle_busy", 32'(busy_lo), 32'd0);
    end

    // 8'b1010_0110, LSB first
    if_lo.in_valid  = 1'b1;
    if_lo.in_vec    = 8'b1010_0110;
    if_lo.out_ready = 1'b1;
    step();
    if_lo.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("lsb_valid", 32'(if_lo.out_valid), 32'd1);
      check_eq("lsb_code", 32'(if_lo.out_code), 32'(codes_lo[i]));
      check_eq("lsb_last", 32'(if_lo.out_last), 32'(i == 3));
      check_eq("lsb_in_ready", 32'(if_lo.in_ready), 32'd0);
      step();
    end
    check_eq("lsb_done_ready", 32'(if_lo.in_ready), 32'd1);
    check_eq("lsb_done_valid", 32'(if_lo.out_valid), 32'd0);

    // Same vector, MSB first
    if_hi.in_valid  = 1'b1;
    if_hi.in_vec    = 8'b1010_0110;
    if_hi.out_ready = 1'b1;
    step();
    if_hi.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("msb_valid", 32'(if_hi.out_valid), 32'd1);
      check_eq("msb_code", 32'(if_hi.out_code), 32'(codes_hi[i]));
      check_eq("msb_last", 32'(if_hi.out_last), 32'(i == 3));
      step();
    end
    check_eq("msb_done_ready", 32'(if_hi.in_ready), 32'd1);
    check_eq("msb_done_busy", 32'(busy_hi), 32'd0);

    // 8'hFF with out_ready toggling: each code held across its stall cycle
    if_lo.in_valid = 1'b1;
    if_lo.in_vec   = 8'hFF;
    step();
    if_lo.in_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if_lo.out_ready = (c % 2 == 0) ? 1'b0 : 1'b1;
      check_eq("ff_valid", 32'(if_lo.out_valid), 32'd1);
      check_eq("ff_busy", 32'(busy_lo), 32'd1);
      check_eq("ff_code", 32'(if_lo.out_code), 32'(c / 2));
      check_eq("ff_last", 32'(if_lo.out_last), 32'(c / 2 == 7));
      step();
    end
    check_eq("ff_done_valid", 32'(if_lo.out_valid), 32'd0);
    check_eq("ff_done_ready", 32'(if_lo.in_ready), 32'd1);

    // Zero vector dropped, then single-bit 8'h10
    if_lo.out_ready = 1'b1;
    if_lo.in_valid  = 1'b1;
    if_lo.in_vec    = 8'h00;
    check_eq("zero_in_ready", 32'(if_lo.in_ready), 32'd1);
    step();
    check_eq("zero_out_valid", 32'(if_lo.out_valid), 32'd0);
    check_eq("zero_busy", 32'(busy_lo), 32'd0);
    if_lo.in_vec = 8'h10;
    step();
    if_lo.in_valid = 1'b0;
    check_eq("one_valid", 32'(if_lo.out_valid), 32'd1);
    check_eq("one_code", 32'(if_lo.out_code), 32'd4);
    check_eq("one_last", 32'(if_lo.out_last), 32'd1);
    step();
    check_eq("one_done_valid", 32'(if_lo.out_valid), 32'd0);

    // Reset mid-vector discards the remaining codes
    if_lo.in_valid = 1'b1;
    if_lo.in_vec   = 8'hF0;
    step();
    if_lo.in_valid = 1'b0;
    check_eq("mid_code0", 32'(if_lo.out_code), 32'd4);
    step();
    check_eq("mid_code1", 32'(if_lo.out_code), 32'd5);
    step();
    check_eq("mid_code2", 32'(if_lo.out_code), 32'd6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_valid", 32'(if_lo.out_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy_lo), 32'd0);
    check_eq("mid_rst_code", 32'(if_lo.out_code), 32'd0);
    check_eq("mid_rst_ready", 32'(if_lo.in_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("mid_post_valid", 32'(if_lo.out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
